alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_pkg.sv | 15 +
 rtl/alarm_key_edge.sv | 19 +
 rtl/alarm_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam int DEF_RING_SECS   = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int DEF_MAX_SNOOZE  = 3;

endpackage

// File: rtl/alarm_key_edge.sv
// Rising-edge detector for a key level; pulse is combinational, same cycle as the 0->1 sample.
// A held key produces a single pulse; history clears on synchronous reset.
module key_edge (
    input  logic CLK,
    input  logic reset,
    input  logic i_key,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge CLK) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_key;
    end

    assign o_edge = i_key & ~r_prev;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm/match/ring/snooze FSM with registered outputs (1 CLK after inputs).
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        tick,
    input  logic        arm,
    input  logic        snooze,
    input  logic        stop,
    input  logic [7:0]  sec,
    input  logic [7:0]  min,
    input  logic [7:0]  hrs,
    input  logic [7:0]  min_alrm,
    input  logic [7:0]  hrs_alrm,
    output logic        alrm,
    output logic [1:0]  state,
    output logic [15:0] time_left,
    output logic [1:0]  snz_used
);

    localparam logic [15:0] RING_LD = 16'(RING_SECS);
`ifdef ALARM_SNOOZE_EN
    localparam logic [15:0] SNZ_LD  = 16'(SNOOZE_SECS);
    localparam logic [1:0]  SNZ_MAX = 2'(MAX_SNOOZE);
`endif

    alarm_state_t r_state;
    logic         r_alrm;
    logic [15:0]  r_time_left;
    logic [1:0]   r_snz_used;

    logic w_snooze_edge;
    logic w_stop_edge;
    logic w_match;
    logic w_tl_last;

    key_edge u_snooze_edge (
        .CLK    (CLK),
        .reset  (reset),
        .i_key  (snooze),
        .o_edge (w_snooze_edge)
    );

    key_edge u_stop_edge (
        .CLK    (CLK),
        .reset  (reset),
        .i_key  (stop),
        .o_edge (w_stop_edge)
    );

`ifndef ALARM_SNOOZE_EN
    logic w_unused_snz;
    assign w_unused_snz = w_snooze_edge;
`endif

    assign w_match   = tick && (sec == 8'd0) && (min == min_alrm) && (hrs == hrs_alrm);
    assign w_tl_last = (r_time_left == 16'd1);

    // Every path into ARMED/DISARMED clears the counters, so they read 0 in those states.
    always_ff @(posedge CLK) begin
        if (reset || !arm) begin
            r_state     <= DISARMED;
            r_alrm      <= 1'b0;
            r_time_left <= 16'd0;
            r_snz_used  <= 2'd0;
        end else begin
            case (r_state)
                DISARMED: begin
                    r_state <= ARMED;
                end
                ARMED: begin
                    if (w_match) begin
                        r_state     <= RINGING;
                        r_alrm      <= 1'b1;
                        r_time_left <= RING_LD;
                    end
                end
                RINGING: begin
                    if (w_stop_edge) begin
                        r_state     <= ARMED;
                        r_alrm      <= 1'b0;
                        r_time_left <= 16'd0;
                        r_snz_used  <= 2'd0;
`ifdef ALARM_SNOOZE_EN
                    end else if (w_snooze_edge && (r_snz_used < SNZ_MAX)) begin
                        r_state     <= SNOOZE;
                        r_alrm      <= 1'b0;
                        r_time_left <= SNZ_LD;
                        r_snz_used  <= r_snz_used + 2'd1;
`endif
                    end else if (tick) begin
                        if (w_tl_last) begin
                            r_state     <= ARMED;
                            r_alrm      <= 1'b0;
                            r_time_left <= 16'd0;
                            r_snz_used  <= 2'd0;
                        end else begin
                            r_time_left <= r_time_left - 16'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (w_stop_edge) begin
                        r_state     <= ARMED;
                        r_alrm      <= 1'b0;
                        r_time_left <= 16'd0;
                        r_snz_used  <= 2'd0;
                    end else if (tick) begin
                        if (w_tl_last) begin
                            r_state     <= RINGING;
                            r_alrm      <= 1'b1;
                            r_time_left <= RING_LD;
                        end else begin
                            r_time_left <= r_time_left - 16'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= DISARMED;
                    r_alrm      <= 1'b0;
                    r_time_left <= 16'd0;
                    r_snz_used  <= 2'd0;
                end
            endcase
        end
    end

    assign alrm      = r_alrm;
    assign state     = r_state;
    assign time_left = r_time_left;
    assign snz_used  = r_snz_used;

endmodule
